apb_wait_ctrl: RTL and testbench

// Parametrised APB slave handshake controller for GPIO and other low-speed peripherals.

---
 rtl/apb_wait_ctrl_if.sv | 27 ++
 rtl/apb_wait_ctrl.sv | 147 ++++++++++++++
 tb/tb_apb_wait_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/apb_wait_ctrl_if.sv
// APB handshake bundle between a bus master and the wait-state controller.
// Handshake: an access starts when Psel and Penable are both high at a rising
// clock edge; the master holds Psel/Penable/Pwrite stable until it samples
// Pready=1, and Pslverr is meaningful only in that same cycle.
interface apb_wait_ctrl_if;
  logic Psel;
  logic Penable;
  logic Pwrite;
  logic Pready;
  logic Pslverr;

  modport master (
    output Psel,
    output Penable,
    output Pwrite,
    input  Pready,
    input  Pslverr
  );

  modport slave (
    input  Psel,
    input  Penable,
    input  Pwrite,
    output Pready,
    output Pslverr
  );
endinterface

// File: rtl/apb_wait_ctrl.sv
// APB slave wait-state controller: inserts a run-time number of wait states
// (separately for reads and writes), honours peripheral back-pressure, can
// force an error completion after a watchdog timeout, and emits one-cycle
// read/write commit strobes. All outputs are registers.
module apb_wait_ctrl #(
  parameter int WAIT_W  = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 0
) (
  input  logic              clock,
  input  logic              reset,
  apb_wait_ctrl_if.slave    bus,
  input  logic [WAIT_W-1:0] rd_wait,
  input  logic [WAIT_W-1:0] wr_wait,
  input  logic              fast,
  input  logic              periph_busy,
  output logic              rd_strobe,
  output logic              wr_strobe,
  output logic              active,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] W_ONE  = WAIT_W'(1);
  localparam logic [TO_W-1:0]   TO_ONE = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_MAX = {TO_W{1'b1}};
  localparam bit                TO_EN  = (TIMEOUT != 0);
  // Last to_cnt value seen in WAIT before the watchdog fires.
  localparam logic [TO_W-1:0]   TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t             state;
  logic               dir;
  logic               err;
  logic [WAIT_W-1:0]  wcnt;
  logic [TO_W-1:0]    to_cnt;
  logic               pready_q;
  logic               pslverr_q;
  logic               rd_q;
  logic               wr_q;
  logic               active_q;

  logic [WAIT_W-1:0]  load_val;
  logic               completing;
  logic               timed_out;

  // Wait-count to load at access start, and this cycle's completion/timeout decisions in WAIT.
  always_comb begin
    load_val   = '0;
    completing = 1'b0;
    timed_out  = 1'b0;
    if (!fast) begin
      load_val = bus.Pwrite ? wr_wait : rd_wait;
    end
    completing = !periph_busy && (wcnt == W_ONE);
    // A normal completion in the same cycle beats the watchdog.
    timed_out  = TO_EN && (to_cnt == TO_LAST) && !completing;
  end

  // Handshake FSM with registered outputs; reset overrides every transition.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      dir       <= 1'b0;
      err       <= 1'b0;
      wcnt      <= '0;
      to_cnt    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      // Completion outputs are pulses; only the transition into DONE raises them.
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.Psel && bus.Penable) begin
            dir      <= bus.Pwrite;
            err      <= 1'b0;
            to_cnt   <= '0;
            wcnt     <= load_val;
            active_q <= 1'b1;
            if (load_val == '0) begin
              state    <= ST_DONE;
              pready_q <= 1'b1;
              rd_q     <= !bus.Pwrite;
              wr_q     <= bus.Pwrite;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            active_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TO_ONE;
          end
          if (!bus.Psel || !bus.Penable) begin
            // Master abandoned the transfer: quietly drop it.
            state    <= ST_IDLE;
            active_q <= 1'b0;
          end else if (timed_out) begin
            state     <= ST_DONE;
            err       <= 1'b1;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end else if (periph_busy) begin
            wcnt <= wcnt;
          end else if (wcnt == W_ONE) begin
            state    <= ST_DONE;
            err      <= 1'b0;
            pready_q <= 1'b1;
            rd_q     <= !dir;
            wr_q     <= dir;
          end else begin
            wcnt <= wcnt - W_ONE;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          active_q <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Pready  = pready_q;
  assign bus.Pslverr = pslverr_q;
  assign rd_strobe   = rd_q;
  assign wr_strobe   = wr_q;
  assign active      = active_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_apb_wait_ctrl.sv
// Directed bench for apb_wait_ctrl (TIMEOUT=8). Each access records, per cycle
// after the access-start edge A, the outputs into bit masks (bit k = cycle A+k)
// which are compared against hand-computed masks.
module tb_apb_wait_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] rd_wait;
  logic [3:0] wr_wait;
  logic       fast;
  logic       periph_busy;
  logic       rd_strobe;
  logic       wr_strobe;
  logic       active;
  logic [1:0] dbg_state;

  int n_tests;
  int n_fail;

  apb_wait_ctrl_if bus ();

  apb_wait_ctrl #(
    .WAIT_W (4),
    .TO_W   (8),
    .TIMEOUT(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .rd_wait    (rd_wait),
    .wr_wait    (wr_wait),
    .fast       (fast),
    .periph_busy(periph_busy),
    .rd_strobe  (rd_strobe),
    .wr_strobe  (wr_strobe),
    .active     (active),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One access: a setup cycle, then the access phase sampled at edge A.
  // After A the sampled inputs are scrambled; they must not affect the transfer.
  // The master releases the bus the cycle after it has seen Pready.
  task automatic run_access(input string name, input logic wr, input logic [3:0] rw,
                            input logic [3:0] ww, input logic f, input logic [31:0] busy_mask,
                            input int reset_at, input int abort_at,
                            input logic [31:0] e_rdy, input logic [31:0] e_err,
                            input logic [31:0] e_rd, input logic [31:0] e_wr,
                            input logic [31:0] e_act);
    logic [31:0] m_rdy, m_err, m_rd, m_wr, m_act, m_done;
    logic        rdy_prev;
    m_rdy = '0; m_err = '0; m_rd = '0; m_wr = '0; m_act = '0; m_done = '0;
    rdy_prev = 1'b0;
    bus.Psel = 1'b1; bus.Penable = 1'b0; bus.Pwrite = wr;
    rd_wait = rw; wr_wait = ww; fast = f; periph_busy = 1'b0;
    tick();                       // setup phase
    bus.Penable = 1'b1;
    periph_busy = busy_mask[0];
    tick();                       // edge A
    rd_wait = ~rw; wr_wait = ~ww; fast = ~f; bus.Pwrite = ~wr;
    for (int k = 1; k <= 12; k++) begin
      m_rdy[k]  = bus.Pready;
      m_err[k]  = bus.Pslverr;
      m_rd[k]   = rd_strobe;
      m_wr[k]   = wr_strobe;
      m_act[k]  = active;
      m_done[k] = (dbg_state == 2'd2);
      if (k == reset_at) begin
        reset = 1'b0; bus.Psel = 1'b0; bus.Penable = 1'b0;
      end else begin
        reset = 1'b1;
      end
      if (k == abort_at) bus.Penable = 1'b0;
      if (rdy_prev) begin
        bus.Psel = 1'b0; bus.Penable = 1'b0;
      end
      rdy_prev = bus.Pready;
      periph_busy = busy_mask[k];
      tick();
    end
    reset = 1'b1; periph_busy = 1'b0; bus.Psel = 1'b0; bus.Penable = 1'b0;
    tick();
    check({name, "_pready"},  m_rdy,  e_rdy);
    check({name, "_pslverr"}, m_err,  e_err);
    check({name, "_rd_strb"}, m_rd,   e_rd);
    check({name, "_wr_strb"}, m_wr,   e_wr);
    check({name, "_active"},  m_act,  e_act);
    check({name, "_st_done"}, m_done, e_rdy);
  endtask

  initial begin
    int          pulses, wr_pulses, first_at, second_at, phase;
    logic        rdy_prev;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0; rd_wait = '0; wr_wait = '0; fast = 1'b0; periph_busy = 1'b0;
    bus.Psel = 1'b1; bus.Penable = 1'b1; bus.Pwrite = 1'b0;
    tick();
    tick();
    // Reset state, even with an access requested on the bus.
    check("rst_pready",  {31'd0, bus.Pready},  32'd0);
    check("rst_pslverr", {31'd0, bus.Pslverr}, 32'd0);
    check("rst_strobes", {30'd0, rd_strobe, wr_strobe}, 32'd0);
    check("rst_active",  {31'd0, active}, 32'd0);
    check("rst_state",   {30'd0, dbg_state}, 32'd0);
    bus.Psel = 1'b0; bus.Penable = 1'b0;
    reset = 1'b1;
    tick();

    // Read, rd_wait=3: Pready/rd_strobe in A+4, active A+1..A+4.
    run_access("rd3", 1'b0, 4'd3, 4'd0, 1'b0, 32'h0, 0, 0,
               32'h10, 32'h0, 32'h10, 32'h0, 32'h1E);
    // Write, wr_wait=7 with fast: everything in A+1 only.
    run_access("wr_fast", 1'b1, 4'd0, 4'd7, 1'b1, 32'h0, 0, 0,
               32'h2, 32'h0, 32'h0, 32'h2, 32'h2);
    // Read, rd_wait=2, busy sampled at A+1 and A+2: Pready in A+5.
    run_access("rd_busy", 1'b0, 4'd2, 4'd0, 1'b0, 32'h6, 0, 0,
               32'h20, 32'h0, 32'h20, 32'h0, 32'h3E);
    // Write, wr_wait=15, busy stuck: timeout error in A+9, idle in A+10.
    run_access("wr_tmo", 1'b1, 4'd0, 4'd15, 1'b0, 32'hFFFF_FFFF, 0, 0,
               32'h200, 32'h200, 32'h0, 32'h0, 32'h3FE);
    // Write, wr_wait=8: completion lands on the timeout cycle and wins.
    run_access("wr_tie", 1'b1, 4'd0, 4'd8, 1'b0, 32'h0, 0, 0,
               32'h200, 32'h0, 32'h0, 32'h200, 32'h3FE);
    // Write, wr_wait=9: watchdog fires first.
    run_access("wr9_tmo", 1'b1, 4'd0, 4'd9, 1'b0, 32'h0, 0, 0,
               32'h200, 32'h200, 32'h0, 32'h0, 32'h3FE);
    // Read with zero wait states and fast=0.
    run_access("rd0", 1'b0, 4'd0, 4'd9, 1'b0, 32'h0, 0, 0,
               32'h2, 32'h0, 32'h2, 32'h0, 32'h2);
    // Read, rd_wait=5, reset sampled at A+2: all quiet from A+3.
    run_access("rd_rst", 1'b0, 4'd5, 4'd0, 1'b0, 32'h0, 2, 0,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h6);
    check("rd_rst_state", {30'd0, dbg_state}, 32'd0);
    // Read, rd_wait=5, Penable dropped at A+2: aborted, no Pready.
    run_access("rd_abort", 1'b0, 4'd5, 4'd0, 1'b0, 32'h0, 0, 2,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h6);

    // Back-to-back writes, wr_wait=1, one setup cycle between them.
    // Pready lands in A+2 and A+6: three non-ready cycles separate the pulses.
    pulses = 0; wr_pulses = 0; first_at = 0; second_at = 0; phase = 0;
    rdy_prev = 1'b0;
    bus.Psel = 1'b1; bus.Penable = 1'b0; bus.Pwrite = 1'b1; wr_wait = 4'd1; fast = 1'b0;
    tick();
    bus.Penable = 1'b1;
    tick();                       // edge A
    for (int c = 1; c <= 12; c++) begin
      if (bus.Pready) begin
        pulses++;
        if (pulses == 1) first_at = c;
        if (pulses == 2) second_at = c;
      end
      if (wr_strobe) wr_pulses++;
      if (rdy_prev) begin
        if (pulses < 2) begin
          bus.Penable = 1'b0;     // setup phase of the next write
          phase = 1;
        end else begin
          bus.Psel = 1'b0; bus.Penable = 1'b0;
          phase = 2;
        end
      end else if (phase == 1) begin
        bus.Penable = 1'b1;
        phase = 0;
      end
      rdy_prev = bus.Pready;
      tick();
    end
    bus.Psel = 1'b0; bus.Penable = 1'b0;
    check("b2b_pulses",    pulses,    32'd2);
    check("b2b_wr_strobe", wr_pulses, 32'd2);
    check("b2b_first",     first_at,  32'd2);
    check("b2b_second",    second_at, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
